// File: rtl/my_74ls161_pkg.sv
// Shared types and constants for the my_74ls161 counter.
package my_74ls161_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = '0;
    localparam cnt_t CNT_MAX  = '1;

endpackage

// File: rtl/my_74ls161.sv
// Synchronous 4-bit binary counter modelled on the 74LS161 (load, dual enable, ripple carry).
// Optional sticky overflow flag OVF when MY_74LS161_OVF_EN is defined.
module my_74ls161
    import my_74ls161_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             Ld,
    input  logic             CTT,
    input  logic             CTP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO
`ifdef MY_74LS161_OVF_EN
    ,
    output logic             OVF
`endif
);

    logic [WIDTH-1:0] r_q;
    logic             w_tc;
    logic             w_cnt_en;

    assign w_tc     = (r_q == {WIDTH{1'b1}});
    assign w_cnt_en = CTT & CTP;

    always_ff @(posedge CP) begin
        if (CR) begin
            r_q <= '0;
        end else if (Ld) begin
            r_q <= D;
        end else if (w_cnt_en) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

`ifdef MY_74LS161_OVF_EN
    logic r_ovf;

    // Clear (reset or load) dominates the wrap-set.
    always_ff @(posedge CP) begin
        if (CR || Ld) begin
            r_ovf <= 1'b0;
        end else if (w_cnt_en && w_tc) begin
            r_ovf <= 1'b1;
        end
    end

    assign OVF = r_ovf;
`endif

    assign Q  = r_q;
    assign CO = CTT & w_tc;

endmodule

// File: tb/tb_my_74ls161.sv
// Self-checking bench for my_74ls161: directed vector table, corner sequences, random vs. model.
module tb_my_74ls161;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       Ld = 1'b0;
    logic       CTT = 1'b0;
    logic       CTP = 1'b0;
    logic [3:0] D = 4'h0;
    logic [3:0] Q;
    logic       CO;
`ifdef MY_74LS161_OVF_EN
    logic       OVF;
`endif

    my_74ls161 #(.WIDTH(4)) dut (
        .CP (CP),
        .CR (CR),
        .Ld (Ld),
        .CTT(CTT),
        .CTP(CTP),
        .D  (D),
        .Q  (Q),
        .CO (CO)
`ifdef MY_74LS161_OVF_EN
        ,
        .OVF(OVF)
`endif
    );

    always #5 CP = ~CP;

    typedef struct {
        string      name;
        logic       cr;
        logic       ld;
        logic       ctt;
        logic       ctp;
        logic [3:0] d;
        logic [3:0] q;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then sample 1 ns later.
    task automatic step(input logic cr, input logic ld, input logic ctt, input logic ctp,
                        input logic [3:0] d);
        CR = cr; Ld = ld; CTT = ctt; CTP = ctp; D = d;
        @(posedge CP);
        #1;
    endtask

    initial begin
        int m_q;
        bit m_ovf;
        int co_hits;
        bit cr_r, ld_r, ctt_r, ctp_r;
        logic [3:0] d_r;

        // name, CR, Ld, CTT, CTP, D, exp Q, exp CO, exp OVF
        vecs.push_back('{"t1_load0",   0, 1, 0, 0, 4'h0, 4'h0, 0, 0});
        vecs.push_back('{"t1_loadD",   0, 1, 0, 0, 4'hD, 4'hD, 0, 0});
        vecs.push_back('{"t1_hold_a",  0, 0, 0, 0, 4'h3, 4'hD, 0, 0});
        vecs.push_back('{"t1_hold_b",  0, 0, 0, 0, 4'h3, 4'hD, 0, 0});
        vecs.push_back('{"t2_part_a",  0, 0, 1, 0, 4'h0, 4'hD, 0, 0});
        vecs.push_back('{"t2_part_b",  0, 0, 1, 0, 4'h0, 4'hD, 0, 0});
        vecs.push_back('{"t3_cnt_E",   0, 0, 1, 1, 4'h0, 4'hE, 0, 0});
        vecs.push_back('{"t3_cnt_F",   0, 0, 1, 1, 4'h0, 4'hF, 1, 0});
        vecs.push_back('{"t3_wrap0",   0, 0, 1, 1, 4'h0, 4'h0, 0, 1});
        vecs.push_back('{"t3_cnt_1",   0, 0, 1, 1, 4'h0, 4'h1, 0, 1});
        vecs.push_back('{"t4_loadF",   0, 1, 0, 0, 4'hF, 4'hF, 0, 0});
        vecs.push_back('{"t4_ctt1",    0, 0, 1, 0, 4'h0, 4'hF, 1, 0});
        vecs.push_back('{"t4_ctt0",    0, 0, 0, 0, 4'h0, 4'hF, 0, 0});
        vecs.push_back('{"t4_ctt1b",   0, 0, 1, 0, 4'h0, 4'hF, 1, 0});
        vecs.push_back('{"t4_wrap",    0, 0, 1, 1, 4'h0, 4'h0, 0, 1});
        vecs.push_back('{"t5_cr_ld",   1, 1, 1, 1, 4'hA, 4'h0, 0, 0});
        vecs.push_back('{"t5_ld_A",    0, 1, 1, 1, 4'hA, 4'hA, 0, 0});
        vecs.push_back('{"ld_at_tc_a", 0, 1, 0, 0, 4'hF, 4'hF, 0, 0});
        vecs.push_back('{"ld_at_tc_b", 0, 1, 1, 1, 4'h5, 4'h5, 0, 0});
        vecs.push_back('{"rst_midcnt", 1, 0, 1, 1, 4'h0, 4'h0, 0, 0});

        @(negedge CP);
        foreach (vecs[i]) begin
            step(vecs[i].cr, vecs[i].ld, vecs[i].ctt, vecs[i].ctp, vecs[i].d);
            check({vecs[i].name, "_Q"},  Q,  vecs[i].q);
            check({vecs[i].name, "_CO"}, {3'b0, CO}, {3'b0, vecs[i].co});
`ifdef MY_74LS161_OVF_EN
            check({vecs[i].name, "_OVF"}, {3'b0, OVF}, {3'b0, vecs[i].ovf});
`endif
        end

        // CO follows CTT between edges while Q sits at terminal count.
        step(0, 1, 0, 0, 4'hF);
        CTT = 1'b1; #1;
        check("t4_comb_co_hi", {3'b0, CO}, 4'h1);
        CTT = 1'b0; #1;
        check("t4_comb_co_lo", {3'b0, CO}, 4'h0);
        CTT = 1'b1; CR = 1'b1; Ld = 1'b1; #1;
        check("t4_comb_co_indep", {3'b0, CO}, 4'h1);
        check("t4_comb_q_held", Q, 4'hF);

        // Full 16-edge cycle from reset.
        step(1, 0, 0, 0, 4'h0);
        check("t6_reset_Q", Q, 4'h0);
        check("t6_reset_CO", {3'b0, CO}, 4'h0);
        co_hits = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 1, 4'h0);
            check("t6_cnt_Q", Q, 4'((i + 1) % 16));
            if (CO) begin
                co_hits++;
                check("t6_co_at_F", Q, 4'hF);
            end
        end
        check("t6_final_Q", Q, 4'h0);
        check("t6_co_hits", 4'(co_hits), 4'd1);
`ifdef MY_74LS161_OVF_EN
        check("t6_ovf", {3'b0, OVF}, 4'h1);
`endif

        // Random stimulus against a rule-level model.
        m_q   = 0;
        m_ovf = 1'b1;
        for (int n = 0; n < 400; n++) begin
            cr_r  = ($urandom_range(0, 15) == 0);
            ld_r  = ($urandom_range(0, 7) == 0);
            ctt_r = ($urandom_range(0, 3) != 0);
            ctp_r = ($urandom_range(0, 3) != 0);
            d_r   = 4'($urandom_range(0, 15));
            if (cr_r) begin
                m_q = 0; m_ovf = 0;
            end else if (ld_r) begin
                m_q = int'(d_r); m_ovf = 0;
            end else if (ctt_r && ctp_r) begin
                if (m_q == 15) m_ovf = 1;
                m_q = (m_q + 1) % 16;
            end
            step(cr_r, ld_r, ctt_r, ctp_r, d_r);
            check("rand_Q", Q, 4'(m_q));
            check("rand_CO", {3'b0, CO}, {3'b0, (ctt_r && m_q == 15)});
`ifdef MY_74LS161_OVF_EN
            check("rand_OVF", {3'b0, OVF}, {3'b0, m_ovf});
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
